// File: rtl/ritc_phase_scan_engine_pkg.sv
// Shared types and constants for the RITC phase-scan engine.
package ritc_phase_scan_engine_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_COUNT   = 3'd2;
    localparam logic [2:0] ST_REPORT  = 3'd3;
    localparam logic [2:0] ST_STEP    = 3'd4;
    localparam logic [2:0] ST_WAITPS  = 3'd5;
    localparam logic [2:0] ST_RETURN  = 3'd6;
    localparam logic [2:0] ST_WAITRET = 3'd7;

    // Sample-select ranges
    localparam int CH0_BASE = 0;
    localparam int CH1_BASE = 12;
    localparam int CH2_BASE = 24;
    localparam int CLK_BASE = 36;
    localparam int VCDL_SEL = 39;

    // Width of the PSDONE timeout counter (timeout must fit in it)
    localparam int PS_CNT_W = 6;

    typedef logic [5:0] sel_t;
    typedef logic [9:0] step_t;

    // Scan configuration captured at START
    typedef struct packed {
        sel_t  sel;
        step_t n;
    } scan_cfg_t;

    // Pick one resynchronised sample bit; selections above VCDL read as 0
    function automatic logic select_sample(
        input sel_t        sel,
        input logic [11:0] ch0,
        input logic [11:0] ch1,
        input logic [11:0] ch2,
        input logic [2:0]  clk_s,
        input logic        vcdl
    );
        logic bit_sel;
        bit_sel = 1'b0;
        if (sel < sel_t'(CH1_BASE))
            bit_sel = ch0[4'(sel - sel_t'(CH0_BASE))];
        else if (sel < sel_t'(CH2_BASE))
            bit_sel = ch1[4'(sel - sel_t'(CH1_BASE))];
        else if (sel < sel_t'(CLK_BASE))
            bit_sel = ch2[4'(sel - sel_t'(CH2_BASE))];
        else if (sel < sel_t'(VCDL_SEL))
            bit_sel = clk_s[2'(sel - sel_t'(CLK_BASE))];
        else if (sel == sel_t'(VCDL_SEL))
            bit_sel = vcdl;
        return bit_sel;
    endfunction

endpackage

// File: rtl/ritc_phase_scan_engine_if.sv
// Control, sample, MMCM phase-shift and result signals of the phase-scan engine.
interface ritc_phase_scan_engine_if
    import ritc_phase_scan_engine_pkg::*;
#(
    parameter int NSAMP_BITS = 8
);
    logic                start;
    sel_t                sel;
    step_t               nsteps;
    logic [2:0]          clock_in;
    logic [11:0]         ch0_in;
    logic [11:0]         ch1_in;
    logic [11:0]         ch2_in;
    logic                vcdl_in;
    logic                psen;
    logic                psincdec;
    logic                psdone;
    logic                res_valid;
    logic                res_ready;
    step_t               res_step;
    logic [NSAMP_BITS:0] res_count;
    logic                busy;
    logic                done;
    logic                err;

    modport slave (
        input  start, sel, nsteps, clock_in, ch0_in, ch1_in, ch2_in, vcdl_in,
        input  psdone, res_ready,
        output psen, psincdec, res_valid, res_step, res_count, busy, done, err
    );

    modport master (
        output start, sel, nsteps, clock_in, ch0_in, ch1_in, ch2_in, vcdl_in,
        output psdone, res_ready,
        input  psen, psincdec, res_valid, res_step, res_count, busy, done, err
    );
endinterface

// File: rtl/ritc_ps_step_ctrl.sv
// Issues one MMCM phase-shift request and waits for PSDONE or a timeout.
// PSEN is registered, so it rises the cycle after i_req. PSDONE is accepted
// from the cycle after PSEN; if none has arrived by PS_TIMEOUT-1 cycles after
// PSEN, o_timeout pulses (the engine's ERR then shows PS_TIMEOUT cycles after PSEN).
module ritc_ps_step_ctrl
    import ritc_phase_scan_engine_pkg::*;
#(
    parameter int PS_TIMEOUT = 63
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_inc,
    input  logic i_psdone,
    output logic o_psen,
    output logic o_psincdec,
    output logic o_done,
    output logic o_timeout
);
    logic                r_busy;
    logic                r_psen;
    logic                r_psincdec;
    logic [PS_CNT_W-1:0] r_wait;
    logic                w_ack;
    logic                w_expired;

    // PSDONE coincident with PSEN is treated as stale and ignored
    assign w_ack     = r_busy && !r_psen && i_psdone;
    assign w_expired = r_busy && !w_ack && (r_wait == PS_CNT_W'(PS_TIMEOUT - 1));

    // One shift in flight at a time; wait counter restarts with each PSEN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_psen     <= 1'b0;
            r_psincdec <= 1'b0;
            r_wait     <= '0;
        end else begin
            r_psen <= 1'b0;
            if (!r_busy) begin
                if (i_req) begin
                    r_busy     <= 1'b1;
                    r_psen     <= 1'b1;
                    r_psincdec <= i_inc;
                    r_wait     <= '0;
                end
            end else if (w_ack || w_expired) begin
                r_busy <= 1'b0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign o_psen     = r_psen;
    assign o_psincdec = r_psincdec;
    assign o_done     = w_ack;
    assign o_timeout  = w_expired;
endmodule

// File: rtl/ritc_phase_scan_engine.sv
// Phase-scan engine: counts ones of a selected sample bit over a fixed window
// at each MMCM fine-phase step, streams the counts, then walks the phase back.
module ritc_phase_scan_engine
    import ritc_phase_scan_engine_pkg::*;
#(
    parameter int NSAMP_BITS = 8,
    parameter int SETTLE     = 4,
    parameter int PS_TIMEOUT = 63
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    ritc_phase_scan_engine_if.slave  io_bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [2:0]          r_state;
    scan_cfg_t           r_cfg;
    step_t               r_step;
    step_t               r_ret;
    step_t               r_res_step;
    logic [SW-1:0]       r_settle;
    logic [NSAMP_BITS-1:0] r_win;
    logic [NSAMP_BITS:0] r_count;
    logic [NSAMP_BITS:0] r_res_count;
    logic                r_bit;
    logic                r_res_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_req;
    logic                w_inc;
    logic                w_ps_done;
    logic                w_ps_timeout;
    logic                w_psen;
    logic                w_psincdec;
    logic [NSAMP_BITS:0] w_count_next;

    assign w_req        = (r_state == ST_STEP) || (r_state == ST_RETURN);
    assign w_inc        = (r_state == ST_STEP);
    assign w_count_next = r_count + {{NSAMP_BITS{1'b0}}, r_bit};

    ritc_ps_step_ctrl #(.PS_TIMEOUT(PS_TIMEOUT)) u_step_ctrl (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (w_req),
        .i_inc      (w_inc),
        .i_psdone   (io_bus.psdone),
        .o_psen     (w_psen),
        .o_psincdec (w_psincdec),
        .o_done     (w_ps_done),
        .o_timeout  (w_ps_timeout)
    );

    // Scan sequencing, sample mux pipeline stage, window counter and result register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_step      <= '0;
            r_ret       <= '0;
            r_res_step  <= '0;
            r_settle    <= '0;
            r_win       <= '0;
            r_count     <= '0;
            r_res_count <= '0;
            r_bit       <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_bit  <= select_sample(r_cfg.sel, io_bus.ch0_in, io_bus.ch1_in,
                                    io_bus.ch2_in, io_bus.clock_in, io_bus.vcdl_in);
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_cfg.sel <= io_bus.sel;
                        r_cfg.n   <= (io_bus.nsteps == '0) ? step_t'(1) : io_bus.nsteps;
                        r_step    <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_settle  <= '0;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SW'(SETTLE - 1)) begin
                        r_count <= '0;
                        r_win   <= '0;
                        r_state <= ST_COUNT;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_COUNT: begin
                    r_count <= w_count_next;
                    r_win   <= r_win + 1'b1;
                    if (&r_win) begin
                        r_res_count <= w_count_next;
                        r_res_step  <= r_step;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (io_bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_step != r_cfg.n - step_t'(1)) begin
                            r_state <= ST_STEP;
                        end else if (r_step == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ret   <= r_step;
                            r_state <= ST_RETURN;
                        end
                    end
                end
                ST_STEP:   r_state <= ST_WAITPS;
                ST_WAITPS: begin
                    if (w_ps_done) begin
                        r_step   <= r_step + step_t'(1);
                        r_settle <= '0;
                        r_state  <= ST_SETTLE;
                    end else if (w_ps_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RETURN: r_state <= ST_WAITRET;
                ST_WAITRET: begin
                    if (w_ps_done) begin
                        if (r_ret == step_t'(1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ret   <= r_ret - step_t'(1);
                            r_state <= ST_RETURN;
                        end
                    end else if (w_ps_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.psen      = w_psen;
    assign io_bus.psincdec  = w_psincdec;
    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_step  = r_res_step;
    assign io_bus.res_count = r_res_count;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.err       = r_err;
endmodule

// File: tb/tb_ritc_phase_scan_engine.sv
// Directed testbench for ritc_phase_scan_engine with a simple MMCM PSDONE responder.
module tb_ritc_phase_scan_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ritc_phase_scan_engine_if #(.NSAMP_BITS(8)) bus();

    ritc_phase_scan_engine #(.NSAMP_BITS(8), .SETTLE(4), .PS_TIMEOUT(63)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int psen_cnt = 0;
    int psen_cyc = 0;
    bit psen_dir[$];
    int res_steps[$];
    int res_counts[$];
    int acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cyc = -1;
    bit resp_en = 1'b0;
    int resp_delay = 3;
    int pend = 0;
    bit vcdl_toggle = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT outputs mid-cycle
    always @(negedge clk) begin
        if (bus.psen === 1'b1) begin
            psen_cnt++;
            psen_dir.push_back(bus.psincdec);
            psen_cyc = cyc;
        end
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            res_steps.push_back(int'(bus.res_step));
            res_counts.push_back(int'(bus.res_count));
            acc_cyc = cyc;
            $display("result step=%0d count=%0d cycle=%0d", bus.res_step, bus.res_count, cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end

    // MMCM model: PSDONE pulse resp_delay cycles after PSEN (keeps running through reset)
    always @(negedge clk) begin
        bus.psdone = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) bus.psdone = 1'b1;
        end
        if (bus.psen === 1'b1 && resp_en) pend = resp_delay;
    end

    // VCDL stimulus: toggles every cycle when enabled
    always @(negedge clk) bus.vcdl_in = vcdl_toggle ? ~bus.vcdl_in : 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        psen_cnt = 0;
        psen_dir.delete();
        res_steps.delete();
        res_counts.delete();
        done_cnt = 0;
        err_cyc = -1;
    endtask

    task automatic start_scan(input logic [5:0] s, input logic [9:0] n);
        bus.sel = s;
        bus.nsteps = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        if (bus.psen !== 1'b0) begin n_err++; $display("FAIL reset_psen: got %b expected 0", bus.psen); end n_vec++;
        if (bus.psincdec !== 1'b0) begin n_err++; $display("FAIL reset_psincdec: got %b expected 0", bus.psincdec); end n_vec++;
        if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end n_vec++;
        if (bus.res_step !== 10'd0) begin n_err++; $display("FAIL reset_res_step: got %0d expected 0", bus.res_step); end n_vec++;
        if (bus.res_count !== 9'd0) begin n_err++; $display("FAIL reset_res_count: got %0d expected 0", bus.res_count); end n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end n_vec++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", bus.err); end n_vec++;
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bit ok;
        logic [3:0] pat;
        clear_obs();
        resp_en = 1'b1; resp_delay = 3;
        bus.ch0_in = 12'h020; bus.res_ready = 1'b1;
        start_scan(6'd5, 10'd3);
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start: got %b expected 1", bus.busy); end n_vec++;
        wait_done(4000, ok);
        if (ok !== 1'b1) begin n_err++; $display("FAIL basic_done_seen: got %b expected 1", ok); end n_vec++;
        if (res_counts.size() != 3) begin n_err++; $display("FAIL basic_nresults: got %0d expected 3", res_counts.size()); end n_vec++;
        for (int i = 0; i < res_counts.size(); i++) begin
            if (res_steps[i] != i) begin n_err++; $display("FAIL basic_step%0d: got %0d expected %0d", i, res_steps[i], i); end n_vec++;
            if (res_counts[i] != 256) begin n_err++; $display("FAIL basic_count%0d: got %0d expected 256", i, res_counts[i]); end n_vec++;
        end
        if (psen_cnt != 4) begin n_err++; $display("FAIL basic_psen_cnt: got %0d expected 4", psen_cnt); end n_vec++;
        pat = '0;
        foreach (psen_dir[i]) pat = {pat[2:0], psen_dir[i]};
        if (pat !== 4'b1100) begin n_err++; $display("FAIL basic_psen_dirs: got %b expected 1100", pat); end n_vec++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b expected 0", bus.err); end n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b expected 0", bus.busy); end n_vec++;
        $display("test_basic done");
    endtask

    task automatic test_vcdl();
        bit ok;
        clear_obs();
        bus.ch0_in = 12'h000; vcdl_toggle = 1'b1; bus.res_ready = 1'b1;
        start_scan(6'd39, 10'd1);
        wait_done(2000, ok);
        vcdl_toggle = 1'b0;
        if (ok !== 1'b1) begin n_err++; $display("FAIL vcdl_done_seen: got %b expected 1", ok); end n_vec++;
        if (res_counts.size() != 1) begin n_err++; $display("FAIL vcdl_nresults: got %0d expected 1", res_counts.size()); end n_vec++;
        if (res_counts.size() > 0) begin
            if (res_counts[0] != 128) begin n_err++; $display("FAIL vcdl_count: got %0d expected 128", res_counts[0]); end n_vec++;
            if (res_steps[0] != 0) begin n_err++; $display("FAIL vcdl_step: got %0d expected 0", res_steps[0]); end n_vec++;
        end
        if (psen_cnt != 0) begin n_err++; $display("FAIL vcdl_psen_cnt: got %0d expected 0", psen_cnt); end n_vec++;
        if (done_cyc - acc_cyc != 1) begin n_err++; $display("FAIL vcdl_done_latency: got %0d expected 1", done_cyc - acc_cyc); end n_vec++;
        $display("test_vcdl done");
    endtask

    task automatic test_sel_bounds();
        bit ok;
        // sel 40 reads constant 0 even with every input high; NSTEPS=0 acts as 1
        clear_obs();
        bus.ch0_in = 12'hFFF; bus.ch1_in = 12'hFFF; bus.ch2_in = 12'hFFF; bus.clock_in = 3'b111;
        start_scan(6'd40, 10'd0);
        wait_done(2000, ok);
        if (ok !== 1'b1) begin n_err++; $display("FAIL sel40_done_seen: got %b expected 1", ok); end n_vec++;
        if (res_counts.size() != 1) begin n_err++; $display("FAIL sel40_nresults: got %0d expected 1", res_counts.size()); end n_vec++;
        if (res_counts.size() > 0) begin
            if (res_counts[0] != 0) begin n_err++; $display("FAIL sel40_count: got %0d expected 0", res_counts[0]); end n_vec++;
        end
        if (psen_cnt != 0) begin n_err++; $display("FAIL sel40_psen_cnt: got %0d expected 0", psen_cnt); end n_vec++;
        // sel 38 is CLOCK[2]
        clear_obs();
        bus.ch0_in = 12'h000; bus.ch1_in = 12'h000; bus.ch2_in = 12'h000; bus.clock_in = 3'b100;
        start_scan(6'd38, 10'd1);
        wait_done(2000, ok);
        if (res_counts.size() != 1) begin n_err++; $display("FAIL sel38_nresults: got %0d expected 1", res_counts.size()); end n_vec++;
        if (res_counts.size() > 0) begin
            if (res_counts[0] != 256) begin n_err++; $display("FAIL sel38_count: got %0d expected 256", res_counts[0]); end n_vec++;
        end
        // sel 13 is CH1[1]
        clear_obs();
        bus.clock_in = 3'b000; bus.ch1_in = 12'h002;
        start_scan(6'd13, 10'd1);
        wait_done(2000, ok);
        if (res_counts.size() != 1) begin n_err++; $display("FAIL sel13_nresults: got %0d expected 1", res_counts.size()); end n_vec++;
        if (res_counts.size() > 0) begin
            if (res_counts[0] != 256) begin n_err++; $display("FAIL sel13_count: got %0d expected 256", res_counts[0]); end n_vec++;
        end
        bus.ch1_in = 12'h000;
        $display("test_sel_bounds done");
    endtask

    task automatic test_timeout();
        bit ok;
        clear_obs();
        resp_en = 1'b0;
        bus.ch0_in = 12'hFFF; bus.res_ready = 1'b1;
        start_scan(6'd0, 10'd2);
        wait_done(2000, ok);
        if (ok !== 1'b1) begin n_err++; $display("FAIL timeout_done_seen: got %b expected 1", ok); end n_vec++;
        if (res_counts.size() != 1) begin n_err++; $display("FAIL timeout_nresults: got %0d expected 1", res_counts.size()); end n_vec++;
        if (psen_cnt != 1) begin n_err++; $display("FAIL timeout_psen_cnt: got %0d expected 1", psen_cnt); end n_vec++;
        if (err_cyc - psen_cyc != 63) begin n_err++; $display("FAIL timeout_err_delay: got %0d expected 63", err_cyc - psen_cyc); end n_vec++;
        if (done_cyc != err_cyc) begin n_err++; $display("FAIL timeout_done_cycle: got %0d expected %0d", done_cyc, err_cyc); end n_vec++;
        if (bus.err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b expected 1", bus.err); end n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b expected 0", bus.busy); end n_vec++;
        repeat (100) tick();
        if (psen_cnt != 1) begin n_err++; $display("FAIL timeout_no_more_psen: got %0d expected 1", psen_cnt); end n_vec++;
        if (bus.err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky: got %b expected 1", bus.err); end n_vec++;
        $display("test_timeout done");
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        logic [1:0] pat;
        clear_obs();
        resp_en = 1'b1; resp_delay = 3;
        bus.ch0_in = 12'hFFF; bus.res_ready = 1'b0;
        start_scan(6'd0, 10'd2);
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL bp_err_cleared: got %b expected 0", bus.err); end n_vec++;
        for (int i = 0; i < 400; i++) begin
            if (bus.res_valid === 1'b1) break;
            tick();
        end
        if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_seen: got %b expected 1", bus.res_valid); end n_vec++;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_step !== 10'd0 || bus.res_count !== 9'd256) bad = 1'b1;
            tick();
        end
        if (bad !== 1'b0) begin n_err++; $display("FAIL bp_hold_stable: got %b expected 0", bad); end n_vec++;
        if (psen_cnt != 0) begin n_err++; $display("FAIL bp_no_psen: got %0d expected 0", psen_cnt); end n_vec++;
        bus.res_ready = 1'b1;
        wait_done(3000, ok);
        if (ok !== 1'b1) begin n_err++; $display("FAIL bp_done_seen: got %b expected 1", ok); end n_vec++;
        if (res_counts.size() != 2) begin n_err++; $display("FAIL bp_nresults: got %0d expected 2", res_counts.size()); end n_vec++;
        for (int i = 0; i < res_counts.size(); i++) begin
            if (res_steps[i] != i) begin n_err++; $display("FAIL bp_step%0d: got %0d expected %0d", i, res_steps[i], i); end n_vec++;
            if (res_counts[i] != 256) begin n_err++; $display("FAIL bp_count%0d: got %0d expected 256", i, res_counts[i]); end n_vec++;
        end
        pat = '0;
        foreach (psen_dir[i]) pat = {pat[0], psen_dir[i]};
        if (psen_cnt != 2 || pat !== 2'b10) begin n_err++; $display("FAIL bp_psen: got cnt=%0d dirs=%b expected cnt=2 dirs=10", psen_cnt, pat); end n_vec++;
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        resp_en = 1'b1; resp_delay = 10;
        bus.ch0_in = 12'hFFF; bus.res_ready = 1'b1;
        start_scan(6'd0, 10'd3);
        for (int i = 0; i < 400; i++) begin
            if (psen_cnt == 1) break;
            tick();
        end
        if (psen_cnt != 1) begin n_err++; $display("FAIL rstmid_psen_seen: got %0d expected 1", psen_cnt); end n_vec++;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        if (bus.psen !== 1'b0) begin n_err++; $display("FAIL rstmid_psen: got %b expected 0", bus.psen); end n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end n_vec++;
        if (bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got valid=%b done=%b err=%b expected 0 0 0", bus.res_valid, bus.done, bus.err);
        end n_vec++;
        rst = 1'b0;
        repeat (30) tick();
        if (psen_cnt != 1 || done_cnt != 0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_late_psdone: got psen=%0d done=%0d busy=%b expected 1 0 0", psen_cnt, done_cnt, bus.busy);
        end n_vec++;
        clear_obs();
        resp_delay = 3;
        start_scan(6'd0, 10'd2);
        wait_done(3000, ok);
        if (ok !== 1'b1 || res_counts.size() != 2 || psen_cnt != 2 || bus.err !== 1'b0) begin
            n_err++; $display("FAIL rstmid_rescan: got done=%b results=%0d psen=%0d err=%b expected 1 2 2 0", ok, res_counts.size(), psen_cnt, bus.err);
        end n_vec++;
        $display("test_reset_mid done");
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_obs();
        resp_en = 1'b1; resp_delay = 3;
        bus.ch0_in = 12'h020; bus.res_ready = 1'b1;
        start_scan(6'd5, 10'd2);
        repeat (20) tick();
        bus.sel = 6'd6; bus.nsteps = 10'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(4000, ok);
        if (ok !== 1'b1) begin n_err++; $display("FAIL sb_done_seen: got %b expected 1", ok); end n_vec++;
        if (res_counts.size() != 2) begin n_err++; $display("FAIL sb_nresults: got %0d expected 2", res_counts.size()); end n_vec++;
        for (int i = 0; i < res_counts.size(); i++) begin
            if (res_counts[i] != 256) begin n_err++; $display("FAIL sb_count%0d: got %0d expected 256", i, res_counts[i]); end n_vec++;
        end
        if (psen_cnt != 2) begin n_err++; $display("FAIL sb_psen_cnt: got %0d expected 2", psen_cnt); end n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sb_busy_end: got %b expected 0", bus.busy); end n_vec++;
        $display("test_start_busy done");
    endtask

    initial begin
        bus.start = 1'b0; bus.sel = '0; bus.nsteps = '0; bus.clock_in = '0;
        bus.ch0_in = '0; bus.ch1_in = '0; bus.ch2_in = '0; bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_vcdl();
        test_sel_bounds();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
